fetch_queue: RTL



---
 rtl/fetch_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Four-wide fetch front end: owns the fetch PC, captures imem groups into a circular queue, presents the oldest four to decode.
// Optional macro FETCHQ_BYPASS_EN: an empty queue forwards the imem group straight to the output slots in the same cycle.
module fetch_queue #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_rd,
   input  logic [31:0] imem_rd2,
   input  logic [31:0] imem_rd3,
   input  logic [31:0] imem_rd4,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic [2:0]  deq_cnt,
   output logic [3:0]  out_valid,
   output logic [31:0] out_instr0,
   output logic [31:0] out_instr1,
   output logic [31:0] out_instr2,
   output logic [31:0] out_instr3,
   output logic [31:0] out_pc0,
   output logic [31:0] out_pc1,
   output logic [31:0] out_pc2,
   output logic [31:0] out_pc3,
   output logic        full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   pc;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic [31:0]   instr_q [DEPTH];
   logic [31:0]   pc_q    [DEPTH];

   logic [31:0]   fetch_word [4];
   logic [31:0]   wr_word    [4];
   logic [31:0]   wr_pc      [4];
   logic [3:0]    wr_en;
   logic [31:0]   slot_instr [4];
   logic [31:0]   slot_pc    [4];

   logic          bypass;
   logic [CW-1:0] deq_req;
   logic [CW-1:0] avail;
   logic [CW-1:0] deq_eff;
   logic [2:0]    skip;
   logic [CW:0]   space;
   logic          enq;

   assign imem_a = pc;

   assign fetch_word[0] = imem_rd;
   assign fetch_word[1] = imem_rd2;
   assign fetch_word[2] = imem_rd3;
   assign fetch_word[3] = imem_rd4;

`ifdef FETCHQ_BYPASS_EN
   assign bypass = (count == '0) && !flush && !reset;
`else
   assign bypass = 1'b0;
`endif

   // Decode never takes more than four, nor more than is actually available.
   always_comb begin
      deq_req = (deq_cnt > 3'd4) ? CW'(4) : CW'(deq_cnt);
      avail   = bypass ? CW'(4) : count;
      deq_eff = (deq_req > avail) ? avail : deq_req;
      skip    = bypass ? deq_eff[2:0] : 3'd0;
      space   = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(deq_eff);
      enq     = (space >= (CW+1)'(4));
   end

   assign full = ~enq;

   // Words consumed directly by a bypass are skipped; the rest pack down from tail.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         wr_word[k] = fetch_word[2'(k) + skip[1:0]];
         wr_pc[k]   = pc + {28'd0, 2'(k) + skip[1:0], 2'b00};
         wr_en[k]   = (3'(k) < (3'd4 - skip));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !flush && enq) begin
         for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
               instr_q[tail + PW'(k)] <= wr_word[k];
               pc_q[tail + PW'(k)]    <= wr_pc[k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc    <= RESET_PC;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         pc    <= {flush_pc[31:2], 2'b00};
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head <= head + PW'(deq_eff - CW'(skip));
         if (enq) begin
            tail  <= tail + PW'(3'd4 - skip);
            pc    <= pc + 32'd16;
            count <= count - deq_eff + CW'(4);
         end else begin
            count <= count - deq_eff;
         end
      end
   end

   always_comb begin
      out_valid = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         slot_instr[i] = 32'h0;
         slot_pc[i]    = 32'h0;
         if (bypass) begin
            out_valid[i]  = 1'b1;
            slot_instr[i] = fetch_word[i];
            slot_pc[i]    = pc + 32'(4 * i);
         end else if (count > CW'(i)) begin
            out_valid[i]  = 1'b1;
            slot_instr[i] = instr_q[head + PW'(i)];
            slot_pc[i]    = pc_q[head + PW'(i)];
         end
      end
   end

   assign out_instr0 = slot_instr[0];
   assign out_instr1 = slot_instr[1];
   assign out_instr2 = slot_instr[2];
   assign out_instr3 = slot_instr[3];
   assign out_pc0    = slot_pc[0];
   assign out_pc1    = slot_pc[1];
   assign out_pc2    = slot_pc[2];
   assign out_pc3    = slot_pc[3];

endmodule
